// File: rtl/btn_debounce_bank_pkg.sv
// Shared definitions for the pushbutton debouncer bank: state encoding
// and the stability-window defaults for hardware and for simulation.
package btn_debounce_bank_pkg;

    localparam logic [1:0] ST_ZERO  = 2'd0;
    localparam logic [1:0] ST_WAIT1 = 2'd1;
    localparam logic [1:0] ST_ONE   = 2'd2;
    localparam logic [1:0] ST_WAIT0 = 2'd3;

    // 10 ms at 100 MHz; short window keeps simulations quick.
    localparam int DB_STABLE_CYCLES = 1_000_000;
    localparam int DB_STABLE_SIM    = 4;

    typedef enum logic [1:0] {
        ZERO  = ST_ZERO,
        WAIT1 = ST_WAIT1,
        ONE   = ST_ONE,
        WAIT0 = ST_WAIT0
    } db_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: 2-FF synchronizer, four-state stability FSM with
// its own counter, and registered level/press-tick outputs.
module debounce_ch
    import btn_debounce_bank_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic db_level,
    output logic db_tick
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic            sync_meta;
    logic            sync_out;
    db_state_e       state;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous pin into the clock domain through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_out  <= sync_meta;
        end
    end

    // Accept a level change only after the synchronized input has held the
    // new value for the whole window; any return to the old value aborts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
            db_tick  <= 1'b0;
        end else begin
            db_tick <= 1'b0;
            case (state)
                ZERO: begin
                    if (sync_out) begin
                        state <= WAIT1;
                        cnt   <= '0;
                    end
                end
                WAIT1: begin
                    if (!sync_out) begin
                        state <= ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ONE;
                        db_level <= 1'b1;
                        db_tick  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ONE: begin
                    if (!sync_out) begin
                        state <= WAIT0;
                        cnt   <= '0;
                    end
                end
                WAIT0: begin
                    if (sync_out) begin
                        state <= ONE;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ZERO;
                        db_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= ZERO;
                    cnt      <= '0;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_bank.sv
// Bank of independent pushbutton debouncers feeding the display-register
// load logic: one clean level and one press tick per button.
module btn_debounce_bank
    import btn_debounce_bank_pkg::*;
#(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] db_level,
    output logic [N-1:0] db_tick
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[g]),
            .db_level(db_level[g]),
            .db_tick (db_tick[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank with a short stability window.
// A run-length model predicts outputs every cycle; directed literal checks
// pin the key latencies.
module tb_btn_debounce_bank;
    import btn_debounce_bank_pkg::*;

    localparam int N  = 4;
    localparam int SC = DB_STABLE_SIM;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] db_level;
    logic [N-1:0] db_tick;

    int checks;
    int failures;
    int pulse_cnt [N];

    btn_debounce_bank #(
        .N            (N),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .db_level(db_level),
        .db_tick (db_tick)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: the pin reaches the decision logic two edges late; a level flips
    // once the delayed input has disagreed with it on SC+1 consecutive edges.
    logic [N-1:0] m_level;
    logic [N-1:0] m_tick;
    logic [N-1:0] d1;
    logic [N-1:0] d2;
    int           run [N];
    logic [N-1:0] nl;
    logic [N-1:0] nt;
    int           nr [N];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_level <= '0;
            m_tick  <= '0;
            d1      <= '0;
            d2      <= '0;
            for (int i = 0; i < N; i++) run[i] <= 0;
        end else begin
            nl = m_level;
            nt = '0;
            for (int i = 0; i < N; i++) begin
                nr[i] = 0;
                if (d2[i] != m_level[i]) begin
                    if (run[i] + 1 == SC + 1) begin
                        nl[i] = ~m_level[i];
                        nt[i] = ~m_level[i];
                        nr[i] = 0;
                    end else begin
                        nr[i] = run[i] + 1;
                    end
                end
            end
            m_level <= nl;
            m_tick  <= nt;
            for (int i = 0; i < N; i++) run[i] <= nr[i];
            d2 <= d1;
            d1 <= btn_raw;
        end
    end

    // Every-cycle comparison against the model, plus per-channel pulse tally.
    always @(negedge clk) begin
        checks++;
        if (db_level !== m_level || db_tick !== m_tick) begin
            failures++;
            $display("[TB] FAIL cycle_cmp t=%0t: got level=%b tick=%b, model level=%b tick=%b",
                     $time, db_level, db_tick, m_level, m_tick);
        end
        for (int i = 0; i < N; i++) if (db_tick[i] === 1'b1) pulse_cnt[i]++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N-1:0] b);
        btn_raw = b;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] exp_level,
                               input logic [N-1:0] exp_tick);
        checks++;
        if (db_level !== exp_level || db_tick !== exp_tick) begin
            failures++;
            $display("[TB] FAIL %s: got level=%b tick=%b, expected level=%b tick=%b",
                     name, db_level, db_tick, exp_level, exp_tick);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int base;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < N; i++) pulse_cnt[i] = 0;

        // 1: reset with all buttons held, then release
        rst = 1'b0;
        applyStimulus(4'hF);
        for (int k = 0; k < 10; k++) begin
            waitCycles(1);
            checkOutput("reset_hold", 4'h0, 4'h0);
        end
        rst = 1'b1;
        waitCycles(6);
        checkOutput("rst_rel_early", 4'h0, 4'h0);
        waitCycles(1);
        checkOutput("rst_rel_tick", 4'hF, 4'hF);
        waitCycles(1);
        checkOutput("rst_rel_after", 4'hF, 4'h0);
        applyStimulus(4'h0);
        waitCycles(10);
        checkOutput("release_all", 4'h0, 4'h0);

        // 2: clean press on channel 0
        base = pulse_cnt[0];
        applyStimulus(4'b0001);
        waitCycles(6);
        checkOutput("press0_early", 4'b0000, 4'b0000);
        waitCycles(1);
        checkOutput("press0_tick", 4'b0001, 4'b0001);
        waitCycles(1);
        checkOutput("press0_after", 4'b0001, 4'b0000);
        waitCycles(12);
        checkOutput("press0_hold", 4'b0001, 4'b0000);
        checkValue("press0_pulses", pulse_cnt[0] - base, 1);
        applyStimulus(4'b0000);
        waitCycles(10);
        checkOutput("press0_release", 4'b0000, 4'b0000);

        // 3: bounce on channel 1
        base = pulse_cnt[1];
        applyStimulus(4'b0010);
        waitCycles(3);
        applyStimulus(4'b0000);
        waitCycles(1);
        applyStimulus(4'b0010);
        waitCycles(6);
        checkOutput("bounce_early", 4'b0000, 4'b0000);
        waitCycles(1);
        checkOutput("bounce_tick", 4'b0010, 4'b0010);
        waitCycles(1);
        checkOutput("bounce_after", 4'b0010, 4'b0000);
        checkValue("bounce_pulses", pulse_cnt[1] - base, 1);

        // 4: release glitch then real release on channel 2
        applyStimulus(4'b0110);
        waitCycles(7);
        checkOutput("press2_tick", 4'b0110, 4'b0100);
        waitCycles(3);
        base = pulse_cnt[2];
        applyStimulus(4'b0010);
        waitCycles(2);
        applyStimulus(4'b0110);
        for (int k = 0; k < 10; k++) begin
            waitCycles(1);
            checkOutput("rel_glitch", 4'b0110, 4'b0000);
        end
        applyStimulus(4'b0010);
        waitCycles(6);
        checkOutput("release2_early", 4'b0110, 4'b0000);
        waitCycles(1);
        checkOutput("release2_fall", 4'b0010, 4'b0000);
        waitCycles(2);
        checkOutput("release2_after", 4'b0010, 4'b0000);
        checkValue("release2_pulses", pulse_cnt[2] - base, 0);

        // 5: reset in the middle of a wait on channel 3
        applyStimulus(4'b1010);
        waitCycles(2);
        checkOutput("midwait_pre", 4'b0010, 4'b0000);
        #2 rst = 1'b0;
        #1 checkOutput("async_reset", 4'b0000, 4'b0000);
        waitCycles(3);
        checkOutput("reset_held", 4'b0000, 4'b0000);
        rst = 1'b1;
        waitCycles(6);
        checkOutput("midwait_early", 4'b0000, 4'b0000);
        waitCycles(1);
        checkOutput("midwait_tick", 4'b1010, 4'b1010);
        waitCycles(1);
        checkOutput("midwait_after", 4'b1010, 4'b0000);

        // 6: simultaneous press on two channels
        applyStimulus(4'b0000);
        waitCycles(10);
        checkOutput("simul_idle", 4'b0000, 4'b0000);
        applyStimulus(4'b1010);
        waitCycles(6);
        checkOutput("simul_early", 4'b0000, 4'b0000);
        waitCycles(1);
        checkOutput("simul_tick", 4'b1010, 4'b1010);
        waitCycles(1);
        checkOutput("simul_after", 4'b1010, 4'b0000);

        waitCycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
